// File: rtl/fft_pkg.sv
// Shared FFT types: Q7.8 sign-magnitude samples, complex words, reorder FSM states
// and the bit-reversal helper used to scatter samples into butterfly order.
package fft_pkg;

  typedef logic [15:0] sample_t;

  typedef struct packed {
    sample_t re;
    sample_t im;
  } complex_t;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam sample_t FP_NEG_ONE = 16'h8100;

  localparam int MAX_ADDR_W = 6;

  // Reverses the low 'width' bits of addr; bits above 'width' come back as zero.
  function automatic logic [MAX_ADDR_W-1:0] bitrev(input logic [MAX_ADDR_W-1:0] addr,
                                                   input int width);
    logic [MAX_ADDR_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_ADDR_W; i++) begin
      if (i < width) begin
        r[i] = addr[width-1-i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_input_reorder.sv
// Collects one frame into a bit-reversed register file, then streams it out as
// first-stage butterfly operand pairs (mem[2k], mem[2k+1]) over valid/ready.
module fft_input_reorder
  import fft_pkg::*;
#(
  parameter  int N_POINTS = 8,
  localparam int ADDR_W   = $clog2(N_POINTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_real,
  input  logic [15:0]       in_imaginary,
  output logic              pair_valid,
  input  logic              pair_ready,
  output logic              pair_last,
  output logic [ADDR_W-2:0] pair_index,
  output logic [15:0]       input_1_real,
  output logic [15:0]       input_1_imaginary,
  output logic [15:0]       input_2_real,
  output logic [15:0]       input_2_imaginary
);

  localparam int                PAIR_W  = ADDR_W - 1;
  localparam logic [ADDR_W-1:0] LAST_WR = ADDR_W'(N_POINTS - 1);
  localparam logic [PAIR_W-1:0] LAST_RD = PAIR_W'(N_POINTS / 2 - 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [PAIR_W-1:0]   rd_cnt_q, rd_cnt_d;
  complex_t            op1_q, op1_d;
  complex_t            op2_q, op2_d;
  complex_t            mem_q [N_POINTS];

  logic                fill_accept;
  logic                pair_accept;
  logic                last_wr;
  logic                last_rd;
  logic [ADDR_W-1:0]   wr_addr;
  logic [PAIR_W-1:0]   rd_load;

  assign fill_accept = (state_q == FILL) && in_valid && !frame_abort;
  assign pair_accept = (state_q == DRAIN) && pair_ready && !frame_abort;
  assign last_wr     = (wr_cnt_q == LAST_WR);
  assign last_rd     = (rd_cnt_q == LAST_RD);
  assign wr_addr     = ADDR_W'(bitrev(MAX_ADDR_W'(wr_cnt_q), ADDR_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (frame_abort) begin
      state_d = FILL;
    end else begin
      case (state_q)
        FILL:    if (fill_accept && last_wr) state_d = DRAIN;
        DRAIN:   if (pair_accept && last_rd) state_d = FILL;
        default: state_d = FILL;
      endcase
    end
  end

  always_comb begin
    in_ready   = (state_q == FILL);
    pair_valid = (state_q == DRAIN);
    pair_last  = (state_q == DRAIN) && last_rd;
    pair_index = rd_cnt_q;
  end

  // The pair to preload: pair 0 when the frame completes, otherwise the next one.
  always_comb begin
    rd_load = (state_q == FILL) ? '0 : rd_cnt_q + PAIR_W'(1);
  end

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    if (frame_abort) begin
      wr_cnt_d = '0;
      rd_cnt_d = '0;
      op1_d    = '0;
      op2_d    = '0;
    end else if (fill_accept) begin
      wr_cnt_d = wr_cnt_q + ADDR_W'(1);
      if (last_wr) begin
        op1_d = mem_q[{rd_load, 1'b0}];
        op2_d = mem_q[{rd_load, 1'b1}];
      end
    end else if (pair_accept) begin
      if (last_rd) begin
        rd_cnt_d = '0;
      end else begin
        rd_cnt_d = rd_load;
        op1_d    = mem_q[{rd_load, 1'b0}];
        op2_d    = mem_q[{rd_load, 1'b1}];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
    end
  end

  // Storage is deliberately not reset; every word is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (fill_accept) begin
      mem_q[wr_addr] <= {in_real, in_imaginary};
    end
  end

  assign input_1_real      = op1_q.re;
  assign input_1_imaginary = op1_q.im;
  assign input_2_real      = op2_q.re;
  assign input_2_imaginary = op2_q.im;

endmodule

// File: tb/tb_fft_input_reorder.sv
// Scoreboard bench for fft_input_reorder (N=8): stimulus queues the expected
// operand pairs, a negedge monitor pops and compares each accepted pair.
module tb_fft_input_reorder;

  localparam int N = 8;

  typedef struct packed {
    logic [1:0]  idx;
    logic        last;
    logic [15:0] r1;
    logic [15:0] i1;
    logic [15:0] r2;
    logic [15:0] i2;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_abort = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_real = '0;
  logic [15:0] in_imaginary = '0;
  logic        pair_valid;
  logic        pair_ready = 1'b0;
  logic        pair_last;
  logic [1:0]  pair_index;
  logic [15:0] input_1_real;
  logic [15:0] input_1_imaginary;
  logic [15:0] input_2_real;
  logic [15:0] input_2_imaginary;

  int    assert_count = 0;
  int    fail_count   = 0;
  pair_t expected_q[$];
  int    first_idx[4] = '{0, 2, 1, 3};

  fft_input_reorder #(.N_POINTS(N)) dut (
    .clk               (clk),
    .rst               (rst),
    .frame_abort       (frame_abort),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_real           (in_real),
    .in_imaginary      (in_imaginary),
    .pair_valid        (pair_valid),
    .pair_ready        (pair_ready),
    .pair_last         (pair_last),
    .pair_index        (pair_index),
    .input_1_real      (input_1_real),
    .input_1_imaginary (input_1_imaginary),
    .input_2_real      (input_2_real),
    .input_2_imaginary (input_2_imaginary)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    assert_count++;
    if (actual !== required) begin
      fail_count++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
    end
  endtask

  // Handshakes complete at posedge; valid/ready are stable across the preceding negedge.
  always @(negedge clk) begin
    pair_t act;
    pair_t want;
    if (!rst && pair_valid && pair_ready) begin
      act.idx  = pair_index;
      act.last = pair_last;
      act.r1   = input_1_real;
      act.i1   = input_1_imaginary;
      act.r2   = input_2_real;
      act.i2   = input_2_imaginary;
      assert_count++;
      if (expected_q.size() == 0) begin
        fail_count++;
        $display("[TB] FAIL unexpected pair: actual=0x%h required=none", act);
      end else begin
        want = expected_q.pop_front();
        if (act !== want) begin
          fail_count++;
          $display("[TB] FAIL pair %0d: actual=0x%h required=0x%h", want.idx, act, want);
        end
      end
    end
  end

  task automatic pushFrame(input logic [15:0] br, input logic [15:0] bi, input int npairs);
    pair_t p;
    int a;
    int b;
    for (int k = 0; k < npairs; k++) begin
      a      = first_idx[k];
      b      = a + 4;
      p.idx  = 2'(k);
      p.last = (k == N / 2 - 1);
      p.r1   = br + 16'(a * 256);
      p.i1   = bi + 16'(a * 128);
      p.r2   = br + 16'(b * 256);
      p.i2   = bi + 16'(b * 128);
      expected_q.push_back(p);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] r, input logic [15:0] im);
    in_valid     = 1'b1;
    in_real      = r;
    in_imaginary = im;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic sendFrame(input logic [15:0] br, input logic [15:0] bi, input int count, input bit gap);
    for (int i = 0; i < count; i++) begin
      if (gap && i > 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      applyStimulus(br + 16'(i * 256), bi + 16'(i * 128));
    end
  endtask

  task automatic fullFrame(input logic [15:0] br, input logic [15:0] bi, input bit gap);
    pushFrame(br, bi, 4);
    sendFrame(br, bi, N, gap);
    checkOutput("first pair latency", 32'(pair_valid), 32'd1);
    checkOutput("first pair index", 32'(pair_index), 32'd0);
    checkOutput("in_ready in drain", 32'(in_ready), 32'd0);
  endtask

  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (pair_valid && pair_ready && pair_last) begin
        @(posedge clk);
        #1;
        checkOutput("in_ready after last pair", 32'(in_ready), 32'd1);
        done = 1'b1;
      end
    end
    if (!done) begin
      @(posedge clk);
      #1;
      checkOutput("drain timeout", 32'd0, 32'd1);
    end
  endtask

  initial begin
    #12;
    checkOutput("reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset pair_valid", 32'(pair_valid), 32'd0);
    checkOutput("reset pair_last", 32'(pair_last), 32'd0);
    checkOutput("reset pair_index", 32'(pair_index), 32'd0);
    checkOutput("reset operands", {input_1_real, input_2_imaginary}, 32'd0);
    checkOutput("reset operands b", {input_1_imaginary, input_2_real}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("[TB] continuous fill and drain");
    pair_ready = 1'b1;
    fullFrame(16'h0000, 16'h0000, 1'b0);
    waitDrain();

    $display("[TB] back-pressure on pair 1");
    fullFrame(16'h1000, 16'h2000, 1'b0);
    @(posedge clk);
    #1;
    pair_ready   = 1'b0;
    in_valid     = 1'b1;
    in_real      = 16'hDEAD;
    in_imaginary = 16'hBEEF;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checkOutput("stall pair_index", 32'(pair_index), 32'd1);
      checkOutput("stall input_1", {input_1_real, input_1_imaginary}, 32'h1200_2100);
      checkOutput("stall input_2", {input_2_real, input_2_imaginary}, 32'h1600_2300);
      checkOutput("stall in_ready", 32'(in_ready), 32'd0);
    end
    in_valid   = 1'b0;
    pair_ready = 1'b1;
    waitDrain();

    $display("[TB] gapped input");
    fullFrame(16'h0030, 16'h0005, 1'b1);
    waitDrain();

    $display("[TB] frame abort");
    pair_ready = 1'b0;
    sendFrame(16'h7000, 16'h7000, N, 1'b0);
    checkOutput("drain before abort", 32'(pair_valid), 32'd1);
    frame_abort = 1'b1;
    @(posedge clk);
    #1;
    frame_abort = 1'b0;
    checkOutput("abort drops pair_valid", 32'(pair_valid), 32'd0);
    checkOutput("abort restores in_ready", 32'(in_ready), 32'd1);
    sendFrame(16'h5000, 16'h5000, 5, 1'b0);
    frame_abort  = 1'b1;
    in_valid     = 1'b1;
    in_real      = 16'h5500;
    in_imaginary = 16'h5580;
    @(posedge clk);
    #1;
    frame_abort = 1'b0;
    in_valid    = 1'b0;
    pair_ready  = 1'b1;
    fullFrame(16'h3000, 16'h3100, 1'b0);
    waitDrain();

    $display("[TB] async reset mid drain");
    pushFrame(16'h0A00, 16'h0B00, 2);
    sendFrame(16'h0A00, 16'h0B00, N, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    pair_ready = 1'b0;
    checkOutput("pair 2 presented", 32'(pair_index), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset pair_valid", 32'(pair_valid), 32'd0);
    checkOutput("async reset in_ready", 32'(in_ready), 32'd1);
    checkOutput("async reset operands", {input_1_real, input_2_imaginary}, 32'd0);
    checkOutput("async reset pair_index", 32'(pair_index), 32'd0);
    @(posedge clk);
    #1;
    rst        = 1'b0;
    pair_ready = 1'b1;
    fullFrame(16'h0C00, 16'h0D00, 1'b0);
    waitDrain();

    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard empty", 32'(expected_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
